mux4_way_16: RTL and testbench
==============================

Name: mux4_way_16

Overview:
- Registered 4-way, 16-bit word selector for the datapath (ALU operand / register-file read selection).
- Picks one of four 16-bit inputs by a 2-bit select.
- Presents the chosen word on a registered output, one clock after sampling.
- Single clock domain; synchronous active-high reset.

Parameters:
- WIDTH, 16, data width of a, b, c, d and out.
- RESET_VALUE, 16'h0000, value loaded into out on reset. Must fit WIDTH bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; sampled on rising clk edge.
- out  output  WIDTH  registered selected word.
- sel  input  2  word select: 0→a, 1→b, 2→c, 3→d.
- a  input  WIDTH  data word 0.
- b  input  WIDTH  data word 1.
- c  input  WIDTH  data word 2.
- d  input  WIDTH  data word 3.
- Instantiation port order: out, sel, a, b, c, d, followed by clk, reset (named connection preferred).

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high.
- Selection is combinational: next_out = a if sel==2'b00, b if 2'b01, c if 2'b10, d if 2'b11.
  - Full case, no priority.
  - No latch inferred.
- Register update on each rising clk edge:
  - reset==1: out <= RESET_VALUE (0x0000 default), regardless of sel or data.
  - else: out <= next_out.
- Latency:
  - Exactly 1 cycle from sampled sel/data to out.
  - out does not change between edges, even if inputs toggle.
- Reset:
  - Asserting reset mid-stream clears out at the next edge. Any in-flight selection is discarded.
  - On the first edge with reset low, out takes the selection sampled at that edge.
  - Before the first reset, out is X in simulation; no power-on value is guaranteed.
- Width rules:
  - Pure bit-for-bit copy; no arithmetic, extension or truncation.
  - All four data inputs and out are exactly WIDTH bits.
- X handling: if sel contains X/Z, out becomes X in simulation. No defined default leg is required.
- Simultaneous changes: sel and data changing in the same cycle is legal. Only values present at the sampling edge matter.
- No enable, no handshake. The register loads every cycle.

Test Plan:
1. Reset: hold reset=1 for 2 edges with sel=3, d=16'hF000 → out==16'h0000 after first edge and stays so.
2. Leg sweep: a=16'h000F, b=16'h00F0, c=16'h0F00, d=16'hF000, reset=0. Apply sel=0,1,2,3 on consecutive cycles → out one cycle later reads 000F, 00F0, 0F00, F000 in order.
3. Latency/hold: sel=1, then change b to 16'hABCD mid-cycle (between edges) → out stays at prior value until the next edge, then shows ABCD.
4. Reset mid-operation: sel=3, d=16'hF000 streaming, assert reset for one edge → out==0000 that cycle. Deassert → out==F000 on the following edge.
5. Simultaneous change: at one edge set sel 0→2 and c 0F00→1234 together → out==1234 after the edge.
6. Random: 1000 cycles of random sel/a/b/c/d with occasional reset → out equals the reference model (previous-cycle select, or 0 on reset) every cycle.

Source files
------------

// File: rtl/mux4_way_16.sv
// ============================================================================
// Module   : mux4_way_16
// Brief    : Registered 4-way word selector. out takes a/b/c/d per sel,
//            one clock after sampling; synchronous active-high reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux4_way_16 #(
    parameter int               WIDTH       = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    output logic [WIDTH-1:0] out,
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic             clk,
    input  logic             reset
);

    logic [WIDTH-1:0] w_next_out;
    logic [WIDTH-1:0] r_out;

    // The default leg only fires for an X/Z select, so the unknown propagates in simulation.
    always_comb begin
        w_next_out = {WIDTH{1'bx}};
        case (sel)
            2'b00:   w_next_out = a;
            2'b01:   w_next_out = b;
            2'b10:   w_next_out = c;
            2'b11:   w_next_out = d;
            default: w_next_out = {WIDTH{1'bx}};
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out <= RESET_VALUE;
        end else begin
            r_out <= w_next_out;
        end
    end

    assign out = r_out;

endmodule

`default_nettype wire

// File: tb/tb_mux4_way_16.sv
// ============================================================================
// Module   : tb_mux4_way_16
// Brief    : Directed and random checks of mux4_way_16 against a queue of
//            expected words pushed at drive time.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux4_way_16;

    localparam int C_WIDTH = 16;

    logic               clk;
    logic               reset;
    logic [1:0]         sel;
    logic [C_WIDTH-1:0] a;
    logic [C_WIDTH-1:0] b;
    logic [C_WIDTH-1:0] c;
    logic [C_WIDTH-1:0] d;
    logic [C_WIDTH-1:0] out;

    logic [C_WIDTH-1:0] exp_q[$];
    int                 vectors;
    int                 miscompares;

    mux4_way_16 #(
        .WIDTH      (C_WIDTH),
        .RESET_VALUE(16'h0000)
    ) dut (
        .out  (out),
        .sel  (sel),
        .a    (a),
        .b    (b),
        .c    (c),
        .d    (d),
        .clk  (clk),
        .reset(reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [C_WIDTH-1:0] ref_word(
        input logic             rst,
        input logic [1:0]       s,
        input logic [C_WIDTH-1:0] va, vb, vc, vd
    );
        if (rst) return '0;
        case (s)
            2'd0:    return va;
            2'd1:    return vb;
            2'd2:    return vc;
            default: return vd;
        endcase
    endfunction

    task automatic check(input string tag, input logic [C_WIDTH-1:0] expv);
        vectors++;
        assert (out === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, out, expv);
        end
    endtask

    task automatic drive(input logic rst, input logic [1:0] s,
                         input logic [C_WIDTH-1:0] va, vb, vc, vd);
        reset = rst;
        sel   = s;
        a     = va;
        b     = vb;
        c     = vc;
        d     = vd;
    endtask

    // Wait for the sampling edge, then compare the oldest queued expectation.
    task automatic tick_check(input string tag);
        logic [C_WIDTH-1:0] expv;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s: observed %h expected <queue empty>", tag, out);
        end else begin
            expv = exp_q.pop_front();
            check(tag, expv);
        end
    endtask

    task automatic apply(input string tag, input logic rst, input logic [1:0] s,
                         input logic [C_WIDTH-1:0] va, vb, vc, vd,
                         input logic [C_WIDTH-1:0] expv);
        drive(rst, s, va, vb, vc, vd);
        exp_q.push_back(expv);
        tick_check(tag);
    endtask

    initial begin
        logic               r_rst;
        logic [1:0]         r_sel;
        logic [C_WIDTH-1:0] ra, rb, rc, rd;

        vectors     = 0;
        miscompares = 0;
        drive(1'b1, 2'd3, 16'h0000, 16'h0000, 16'h0000, 16'hF000);

        // Reset held for two edges with d selected
        apply("reset_edge1", 1'b1, 2'd3, 16'h000F, 16'h00F0, 16'h0F00, 16'hF000, 16'h0000);
        apply("reset_edge2", 1'b1, 2'd3, 16'h000F, 16'h00F0, 16'h0F00, 16'hF000, 16'h0000);

        // Leg sweep
        apply("leg_a", 1'b0, 2'd0, 16'h000F, 16'h00F0, 16'h0F00, 16'hF000, 16'h000F);
        apply("leg_b", 1'b0, 2'd1, 16'h000F, 16'h00F0, 16'h0F00, 16'hF000, 16'h00F0);
        apply("leg_c", 1'b0, 2'd2, 16'h000F, 16'h00F0, 16'h0F00, 16'hF000, 16'h0F00);
        apply("leg_d", 1'b0, 2'd3, 16'h000F, 16'h00F0, 16'h0F00, 16'hF000, 16'hF000);

        // Hold between edges: sel=1 first, then b changes mid-cycle
        apply("hold_pre", 1'b0, 2'd1, 16'h000F, 16'h00F0, 16'h0F00, 16'hF000, 16'h00F0);
        #3;
        b = 16'hABCD;
        #1;
        check("hold_mid", 16'h00F0);
        exp_q.push_back(16'hABCD);
        tick_check("hold_post");

        // Reset mid-stream with d streaming
        apply("mid_stream", 1'b0, 2'd3, 16'h000F, 16'h00F0, 16'h0F00, 16'hF000, 16'hF000);
        apply("mid_reset",  1'b1, 2'd3, 16'h000F, 16'h00F0, 16'h0F00, 16'hF000, 16'h0000);
        apply("mid_resume", 1'b0, 2'd3, 16'h000F, 16'h00F0, 16'h0F00, 16'hF000, 16'hF000);

        // sel and c change together at one edge
        apply("simul_pre",  1'b0, 2'd0, 16'h000F, 16'h00F0, 16'h0F00, 16'hF000, 16'h000F);
        apply("simul_post", 1'b0, 2'd2, 16'h000F, 16'h00F0, 16'h1234, 16'hF000, 16'h1234);

        // Random traffic with occasional reset
        for (int i = 0; i < 1000; i++) begin
            r_rst = ($urandom_range(0, 15) == 0);
            r_sel = 2'($urandom_range(0, 3));
            ra    = 16'($urandom);
            rb    = 16'($urandom);
            rc    = 16'($urandom);
            rd    = 16'($urandom);
            apply("random", r_rst, r_sel, ra, rb, rc, rd,
                  ref_word(r_rst, r_sel, ra, rb, rc, rd));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
